// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus into the video RAM arbiter.
// The requester holds req/we/addr/wdata stable until it sees ack.
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetches have fixed priority over
// CPU accesses; vdg_data holds the last fetched byte between fetches.
//
// state  | meaning
// IDLE   | choose next access: video fetch if pending, else CPU request
// V_WAIT | SRAM capturing the video address
// V_CAP  | video read data valid on ram_rdata, loaded into vdg_data on exit
// C_WR   | SRAM writing CPU data this edge
// C_WAIT | SRAM capturing the CPU read address
// C_CAP  | CPU read data valid on ram_rdata, loaded into cpu_rdata on exit
// ACK    | cpu_ack high for this single cycle
module vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [DATA_W-1:0] vdg_data,
  vram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, V_WAIT, V_CAP, C_WR, C_WAIT, C_CAP, ACK
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_q_d;
  logic              vid_valid, vid_valid_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_we_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic [DATA_W-1:0] vdg_data_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic              cpu_ack_d;
  logic              vid_pending;

  assign vid_pending = !vid_valid || (vdg_addr != vid_addr_q);

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      vid_addr_q    <= '0;
      vid_valid     <= 1'b0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      vdg_data      <= '0;
      cpu.cpu_rdata <= '0;
      cpu.cpu_ack   <= 1'b0;
    end else begin
      state         <= next_state;
      vid_addr_q    <= vid_addr_q_d;
      vid_valid     <= vid_valid_d;
      ram_addr      <= ram_addr_d;
      ram_we        <= ram_we_d;
      ram_wdata     <= ram_wdata_d;
      vdg_data      <= vdg_data_d;
      cpu.cpu_rdata <= cpu_rdata_d;
      cpu.cpu_ack   <= cpu_ack_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (vid_pending)                    next_state = V_WAIT;
        else if (cpu.cpu_req && cpu.cpu_we) next_state = C_WR;
        else if (cpu.cpu_req)               next_state = C_WAIT;
      end
      V_WAIT:  next_state = V_CAP;
      V_CAP:   next_state = IDLE;
      C_WR:    next_state = ACK;
      C_WAIT:  next_state = C_CAP;
      C_CAP:   next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    vid_addr_q_d = vid_addr_q;
    vid_valid_d  = vid_valid;
    ram_addr_d   = ram_addr;
    ram_we_d     = ram_we;
    ram_wdata_d  = ram_wdata;
    vdg_data_d   = vdg_data;
    cpu_rdata_d  = cpu.cpu_rdata;
    cpu_ack_d    = cpu.cpu_ack;
    case (state)
      IDLE: begin
        if (vid_pending) begin
          ram_addr_d   = vdg_addr;
          ram_we_d     = 1'b0;
          vid_addr_q_d = vdg_addr;
          vid_valid_d  = 1'b1;
        end else if (cpu.cpu_req && cpu.cpu_we) begin
          ram_addr_d  = cpu.cpu_addr;
          ram_wdata_d = cpu.cpu_wdata;
          ram_we_d    = 1'b1;
        end else if (cpu.cpu_req) begin
          ram_addr_d = cpu.cpu_addr;
          ram_we_d   = 1'b0;
        end
      end
      V_CAP: vdg_data_d = ram_rdata;
      C_WR: begin
        ram_we_d  = 1'b0;
        cpu_ack_d = 1'b1;
        // Writing the byte on screen invalidates it so the display refetches.
        if (cpu.cpu_addr == vid_addr_q) vid_valid_d = 1'b0;
      end
      C_CAP: begin
        cpu_rdata_d = ram_rdata;
        cpu_ack_d   = 1'b1;
      end
      ACK: cpu_ack_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous SRAM.
module tb_vram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic              clk_25 = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] vdg_addr;
  logic [DATA_W-1:0] vdg_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int we_cycles = 0;
  int ack_cycles = 0;
  int mark;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .vdg_addr  (vdg_addr),
    .vdg_data  (vdg_data),
    .cpu       (cpu_bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #20 clk_25 = ~clk_25;

  // SRAM: unwritten locations return a fixed preload pattern.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  bit                written [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    case (a)
      14'h0123: init_val = 8'hA5;
      14'h0010: init_val = 8'h77;
      14'h0020: init_val = 8'h11;
      14'h0011: init_val = 8'hC3;
      default:  init_val = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk_25) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  always @(negedge clk_25) begin
    if (ram_we === 1'b1) we_cycles++;
    if (cpu_bus.cpu_ack === 1'b1) ack_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25);
      @(negedge clk_25);
      #1;
    end
  endtask

  task automatic cpu_drive(input logic req, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_bus.cpu_req   = req;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = a;
    cpu_bus.cpu_wdata = d;
  endtask

  initial begin
    reset_n  = 1'b0;
    vdg_addr = 14'h0123;
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick(2);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_vdg_data", vdg_data, 0);
    chk("rst_cpu_ack", cpu_bus.cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_bus.cpu_rdata, 0);

    // Reset fetch
    reset_n = 1'b1;
    mark = we_cycles;
    tick();
    chk("rf_ram_addr", ram_addr, 14'h0123);
    tick();
    chk("rf_vdg_early", vdg_data, 0);
    tick();
    chk("rf_vdg_data", vdg_data, 8'hA5);
    chk("rf_no_we", we_cycles - mark, 0);

    // CPU write 0x0200 <- 0x3C
    cpu_drive(1'b1, 1'b1, 14'h0200, 8'h3C);
    mark = we_cycles;
    tick();
    chk("wr_we_on", ram_we, 1);
    chk("wr_addr", ram_addr, 14'h0200);
    chk("wr_wdata", ram_wdata, 8'h3C);
    chk("wr_ack_early", cpu_bus.cpu_ack, 0);
    tick();
    chk("wr_we_off", ram_we, 0);
    chk("wr_ack", cpu_bus.cpu_ack, 1);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("wr_ack_drop", cpu_bus.cpu_ack, 0);
    chk("wr_we_len", we_cycles - mark, 1);

    // CPU read back 0x0200
    cpu_drive(1'b1, 1'b0, 14'h0200, 8'h00);
    tick();
    chk("rd_addr", ram_addr, 14'h0200);
    tick();
    chk("rd_ack_early", cpu_bus.cpu_ack, 0);
    tick();
    chk("rd_ack", cpu_bus.cpu_ack, 1);
    chk("rd_data", cpu_bus.cpu_rdata, 8'h3C);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick();
    chk("rd_ack_drop", cpu_bus.cpu_ack, 0);

    // Collision: video change and CPU read in the same cycle
    vdg_addr = 14'h0010;
    cpu_drive(1'b1, 1'b0, 14'h0020, 8'h00);
    mark = ack_cycles;
    tick();
    chk("col_vid_first", ram_addr, 14'h0010);
    tick(2);
    chk("col_vdg_data", vdg_data, 8'h77);
    tick();
    chk("col_cpu_addr", ram_addr, 14'h0020);
    tick(2);
    chk("col_ack", cpu_bus.cpu_ack, 1);
    chk("col_rdata", cpu_bus.cpu_rdata, 8'h11);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick(3);
    chk("col_single_ack", ack_cycles - mark, 1);

    // Address change mid-fetch
    vdg_addr = 14'h0030;
    tick(3);
    chk("mf_pre_fetch", vdg_data, 8'h6A);
    vdg_addr = 14'h0010;
    tick();
    chk("mf_issue_old", ram_addr, 14'h0010);
    vdg_addr = 14'h0011;
    tick(2);
    chk("mf_old_done", vdg_data, 8'h77);
    tick();
    chk("mf_refetch", ram_addr, 14'h0011);
    tick(2);
    chk("mf_new_data", vdg_data, 8'hC3);

    // Write-through refetch of the displayed byte
    cpu_drive(1'b1, 1'b1, 14'h0011, 8'hE0);
    mark = we_cycles;
    tick(2);
    chk("wt_ack", cpu_bus.cpu_ack, 1);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick(2);
    chk("wt_refetch", ram_addr, 14'h0011);
    chk("wt_read", ram_we, 0);
    tick(2);
    chk("wt_vdg_data", vdg_data, 8'hE0);
    chk("wt_we_len", we_cycles - mark, 1);

    // Reset during a write
    cpu_drive(1'b1, 1'b1, 14'h0040, 8'h99);
    tick();
    chk("rw_in_cwr", ram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_we_async", ram_we, 0);
    chk("rw_ack_async", cpu_bus.cpu_ack, 0);
    chk("rw_vdg_rst", vdg_data, 0);
    cpu_drive(1'b0, 1'b0, '0, '0);
    vdg_addr = 14'h0123;
    tick(2);
    mark = ack_cycles;
    reset_n = 1'b1;
    tick();
    chk("rw_ram_addr", ram_addr, 14'h0123);
    tick(2);
    chk("rw_vdg_data", vdg_data, 8'hA5);
    tick(3);
    chk("rw_no_ack", ack_cycles - mark, 0);

    // Aborted write must not have reached the SRAM
    cpu_drive(1'b1, 1'b0, 14'h0040, 8'h00);
    tick(3);
    chk("rw_rd_ack", cpu_bus.cpu_ack, 1);
    chk("rw_mem_intact", cpu_bus.cpu_rdata, 8'h1A);
    cpu_drive(1'b0, 1'b0, '0, '0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
